// File: rtl/cpu_pkg.sv
// Shared ISA encodings, issue-FSM states and per-class execute lengths for the
// instruction issue stage.
package cpu_pkg;

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] CMP     = 2'b01;

  localparam logic [1:0] NSEL_RM = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_RN = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP
  } issue_state_e;

  localparam logic [2:0] LEN_MOV_IMM = 3'd2;
  localparam logic [2:0] LEN_MOV_REG = 3'd5;
  localparam logic [2:0] LEN_CMP     = 3'd4;
  localparam logic [2:0] LEN_ALU     = 3'd5;

  // Number of clocks the controller needs for an instruction; 0 means unsupported.
  function automatic logic [2:0] exec_len(input logic [15:0] instr);
    logic [2:0] len;
    len = 3'd0;
    if (instr[15:13] == OP_MOV && instr[12:11] == MOV_IMM)
      len = LEN_MOV_IMM;
    else if (instr[15:13] == OP_MOV && instr[12:11] == MOV_REG)
      len = LEN_MOV_REG;
    else if (instr[15:13] == OP_ALU)
      len = (instr[12:11] == CMP) ? LEN_CMP : LEN_ALU;
    return len;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Parameterised synchronous FIFO; a push while full is accepted only when a
// pop happens in the same cycle.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop)
        rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)
        count_q <= count_q + CW'(1);
      else if (do_pop && !do_push)
        count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/instr_issue.sv
// Instruction buffer + decode ahead of the CPU controller: queues instructions,
// latches the head into IR and holds the controller's start for the class length.
module instr_issue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [IW-1:0] in_instr,
  output logic          in_ready,
  input  logic          w,
  input  logic [1:0]    nsel,
  output logic          s,
  output logic [2:0]    opcode,
  output logic [1:0]    op,
  output logic [1:0]    ALUop,
  output logic [1:0]    shift,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic [15:0]   sximm8,
  output logic [15:0]   sximm5,
  output logic [CW-1:0] count,
  output logic          illegal,
  output logic          busy
);

  issue_state_e  state_q;
  logic [IW-1:0] ir_q;
  logic [2:0]    cnt_q;
  logic          s_q, illegal_q;

  logic [IW-1:0] head;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic [2:0]    head_len;

  // Pop is independent of in_valid, so in_ready may look at it without a loop.
  assign pop      = (state_q == S_IDLE) && !fifo_empty && w;
  assign in_ready = !fifo_full || pop;
  assign push     = in_valid && in_ready;
  assign head_len = exec_len(head);

  instr_fifo #(.DEPTH(DEPTH), .W(IW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (in_instr),
    .dout_o  (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      cnt_q     <= '0;
      s_q       <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            ir_q <= head;
            if (head_len != 3'd0) begin
              cnt_q   <= head_len;
              s_q     <= 1'b1;
              state_q <= S_RUN;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (cnt_q == 3'd1) begin
            s_q     <= 1'b0;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_GAP: state_q <= S_IDLE;
        default: begin
          s_q     <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign s       = s_q;
  assign illegal = illegal_q;
  assign busy    = (state_q != S_IDLE);

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign ALUop  = ir_q[12:11];
  assign shift  = ir_q[4:3];
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

  always_comb begin
    readnum = 3'd0;
    case (nsel)
      NSEL_RM: readnum = ir_q[2:0];
      NSEL_RD: readnum = ir_q[7:5];
      NSEL_RN: readnum = ir_q[10:8];
      default: readnum = 3'd0;
    endcase
  end

  assign writenum = readnum;

endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue: reset, each instruction class, illegal drop,
// FIFO fill/drain ordering and reset during execution.
module tb_instr_issue;
  localparam int DEPTH = 4;
  localparam int IW    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, in_valid, w;
  logic [IW-1:0] in_instr;
  logic          in_ready;
  logic [1:0]    nsel;
  logic          s;
  logic [2:0]    opcode;
  logic [1:0]    op, ALUop, shift;
  logic [2:0]    readnum, writenum;
  logic [15:0]   sximm8, sximm5;
  logic [CW-1:0] count;
  logic          illegal, busy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  instr_issue #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .w(w), .nsel(nsel), .s(s), .opcode(opcode), .op(op),
    .ALUop(ALUop), .shift(shift), .readnum(readnum), .writenum(writenum),
    .sximm8(sximm8), .sximm5(sximm5), .count(count), .illegal(illegal), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Measures consecutive s-high cycles and the following s-low busy cycles.
  task automatic measure(output int n, output int g);
    int guard;
    n = 0; g = 0; guard = 0;
    while (!s && guard < 20) begin step(); guard++; end
    while (s && guard < 40) begin n++; step(); guard++; end
    while (busy && !s && guard < 60) begin g++; step(); guard++; end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; w = 1'b0; nsel = 2'b00;
    step(); step();
    checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else passed++;
    checks++; if ({s, illegal, busy} !== 3'b000) $display("FAIL reset_s_ill_busy: got %03b want 000", {s, illegal, busy}); else passed++;
    checks++; if ({opcode, sximm8} !== 19'd0) $display("FAIL reset_ir: got %h want 0", {opcode, sximm8}); else passed++;
    reset = 1'b0;
    step();
    checks++; if (busy !== 1'b0) $display("FAIL reset_idle: busy got %0b want 0", busy); else passed++;
  endtask

  task automatic test_mov_imm();
    int n, g;
    w = 1'b1; in_valid = 1'b1; in_instr = 16'hD205;
    step();
    in_valid = 1'b0;
    checks++; if ({count, s} !== {3'd1, 1'b0}) $display("FAIL mov_pushed: count/s got %0d/%0b want 1/0", count, s); else passed++;
    step();
    checks++; if ({count, s} !== {3'd0, 1'b1}) $display("FAIL mov_pop: count/s got %0d/%0b want 0/1", count, s); else passed++;
    checks++; if (sximm8 !== 16'h0005) $display("FAIL mov_sximm8: got %h want 0005", sximm8); else passed++;
    nsel = 2'b10; #1;
    checks++; if ({readnum, writenum} !== {3'd2, 3'd2}) $display("FAIL mov_readnum: got %0d/%0d want 2/2", readnum, writenum); else passed++;
    measure(n, g);
    checks++; if (n !== 2) $display("FAIL mov_s_len: got %0d want 2", n); else passed++;
    checks++; if (g !== 1) $display("FAIL mov_gap: got %0d want 1", g); else passed++;
  endtask

  task automatic test_alu();
    int n, g;
    in_valid = 1'b1; in_instr = 16'hA0A1;
    step();
    in_valid = 1'b0;
    step();
    checks++; if ({s, opcode, ALUop} !== {1'b1, 3'b101, 2'b00}) $display("FAIL alu_issue: got %b want 1_101_00", {s, opcode, ALUop}); else passed++;
    nsel = 2'b10; #1;
    checks++; if (readnum !== 3'd0) $display("FAIL alu_rn: got %0d want 0", readnum); else passed++;
    nsel = 2'b00; #1;
    checks++; if (readnum !== 3'd1) $display("FAIL alu_rm: got %0d want 1", readnum); else passed++;
    nsel = 2'b01; #1;
    checks++; if ({readnum, writenum} !== {3'd5, 3'd5}) $display("FAIL alu_rd: got %0d/%0d want 5/5", readnum, writenum); else passed++;
    nsel = 2'b11; #1;
    checks++; if (readnum !== 3'd0) $display("FAIL alu_nsel11: got %0d want 0", readnum); else passed++;
    measure(n, g);
    checks++; if (n !== 5) $display("FAIL alu_s_len: got %0d want 5", n); else passed++;
    checks++; if (g !== 1) $display("FAIL alu_gap: got %0d want 1", g); else passed++;
  endtask

  task automatic test_cmp();
    int n, g;
    in_valid = 1'b1; in_instr = 16'hA901;
    step();
    in_valid = 1'b0;
    measure(n, g);
    checks++; if (n !== 4) $display("FAIL cmp_s_len: got %0d want 4", n); else passed++;
    checks++; if (g !== 1) $display("FAIL cmp_gap: got %0d want 1", g); else passed++;
    checks++; if ({ALUop, shift, sximm5} !== {2'b01, 2'b00, 16'h0001}) $display("FAIL cmp_fields: got %h want 1_0_0001", {ALUop, shift, sximm5}); else passed++;
  endtask

  task automatic test_illegal();
    int n, g;
    in_valid = 1'b1; in_instr = 16'hE000;
    step();
    in_instr = 16'hA901;
    step();
    in_valid = 1'b0;
    checks++; if ({illegal, s, busy} !== 3'b100) $display("FAIL ill_pulse: got %03b want 100", {illegal, s, busy}); else passed++;
    checks++; if ({opcode, count} !== {3'b111, 3'd1}) $display("FAIL ill_ir_count: got %0o/%0d want 7/1", opcode, count); else passed++;
    step();
    checks++; if ({illegal, s} !== 2'b01) $display("FAIL ill_next: got %02b want 01", {illegal, s}); else passed++;
    measure(n, g);
    checks++; if (n !== 4) $display("FAIL ill_next_len: got %0d want 4", n); else passed++;
  endtask

  task automatic test_fill_drain();
    logic [15:0] v [5];
    int lens [4];
    int n, g;
    v[0] = 16'hD205; v[1] = 16'hC0A1; v[2] = 16'hA901; v[3] = 16'hA0A1; v[4] = 16'hD2F9;
    lens[0] = 2; lens[1] = 5; lens[2] = 4; lens[3] = 5;
    w = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = v[i];
      step();
      checks++; if (count !== CW'((i < 4) ? i + 1 : 4)) $display("FAIL fill_count%0d: got %0d want %0d", i, count, (i < 4) ? i + 1 : 4); else passed++;
      checks++; if (in_ready !== (i < 3)) $display("FAIL fill_ready%0d: got %0b want %0b", i, in_ready, (i < 3)); else passed++;
    end
    in_valid = 1'b0;
    w = 1'b1;
    for (int k = 0; k < 4; k++) begin
      measure(n, g);
      checks++; if (n !== lens[k]) $display("FAIL drain_len%0d: got %0d want %0d", k, n, lens[k]); else passed++;
      checks++; if ({opcode, op, sximm8[7:0]} !== {v[k][15:11], v[k][7:0]}) $display("FAIL drain_order%0d: got %h want %h", k, {opcode, op, sximm8[7:0]}, {v[k][15:11], v[k][7:0]}); else passed++;
    end
    step(); step();
    checks++; if ({count, busy, s} !== {3'd0, 1'b0, 1'b0}) $display("FAIL drain_empty: count/busy/s got %0d/%0b/%0b want 0/0/0", count, busy, s); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int n, g;
    w = 1'b1; in_valid = 1'b1; in_instr = 16'hA0A1;
    step();
    in_instr = 16'hD205;
    step();
    in_valid = 1'b0;
    step();
    checks++; if ({s, busy, count} !== {1'b1, 1'b1, 3'd1}) $display("FAIL rst_mid_pre: s/busy/count got %0b/%0b/%0d want 1/1/1", s, busy, count); else passed++;
    reset = 1'b1;
    step();
    checks++; if ({s, busy, count, in_ready} !== {1'b0, 1'b0, 3'd0, 1'b1}) $display("FAIL rst_mid_post: s/busy/count/rdy got %0b/%0b/%0d/%0b want 0/0/0/1", s, busy, count, in_ready); else passed++;
    checks++; if (opcode !== 3'd0) $display("FAIL rst_mid_ir: got %0o want 0", opcode); else passed++;
    reset = 1'b0;
    in_valid = 1'b1; in_instr = 16'hD2F9;
    step();
    in_valid = 1'b0;
    measure(n, g);
    checks++; if (n !== 2) $display("FAIL rst_mid_reissue: got %0d want 2", n); else passed++;
    checks++; if (sximm8 !== 16'hFFF9) $display("FAIL rst_mid_sximm8: got %h want fff9", sximm8); else passed++;
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_alu();
    test_cmp();
    test_illegal();
    test_fill_drain();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
